// File: rtl/yen_freq_meter.sv
// Multi-channel rising-edge frequency meter: synchronises all channels, counts
// edges on the selected one over a programmable gate window, holds a saturating result.
module yen_freq_meter #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int GATE_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic [CHANNELS-1:0]         ch_in,
    input  logic [$clog2(CHANNELS)-1:0] ch_sel,
    input  logic [GATE_W-1:0]           gate_len,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            count,
    output logic                        ovf
);

    localparam int SEL_W = $clog2(CHANNELS);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

    state_t              state, state_nxt;
    logic [CHANNELS-1:0] sync1, sync2;
    logic [SEL_W-1:0]    ch_lat;
    logic [GATE_W-1:0]   gl_lat;
    logic [GATE_W-1:0]   timer;
    logic [CNT_W-1:0]    acc, acc_nxt;
    logic                ovf_acc, ovf_nxt;
    logic                prev;
    logic                sel_bit;
    logic                rise;
    logic                accept;

    assign accept  = ena && start && (state == IDLE || state == DONE);
    assign sel_bit = sync2[ch_lat];
    assign rise    = sel_bit && !prev;

    // NOTE: every register uses non-blocking assignment so all flops sample the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: each combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (!ena) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = (gate_len == '0) ? DONE : SETTLE;
                SETTLE:     if (timer == '0) state_nxt = GATE;
                GATE:       if (timer == '0) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == SETTLE) || (state == GATE);
        done = (state == DONE);
    end

    // Saturating accumulate; an increment attempted at full scale flags overflow.
    always_comb begin
        acc_nxt = acc;
        ovf_nxt = ovf_acc;
        if (rise) begin
            if (&acc) ovf_nxt = 1'b1;
            else      acc_nxt = acc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= 1'b0;
            ch_lat  <= '0;
            gl_lat  <= '0;
            timer   <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            sync1 <= ch_in;
            sync2 <= sync1;
            // Tracks the latched channel every cycle, so by the first GATE cycle
            // a channel switch can no longer look like a rising edge.
            prev  <= sel_bit;
            if (accept) begin
                ch_lat  <= (32'(ch_sel) < CHANNELS) ? ch_sel : '0;
                gl_lat  <= gate_len;
                acc     <= '0;
                ovf_acc <= 1'b0;
                timer   <= GATE_W'(1);
                if (gate_len == '0) begin
                    count <= '0;
                    ovf   <= 1'b0;
                end
            end else if (ena) begin
                case (state)
                    SETTLE: timer <= (timer == '0) ? gl_lat - GATE_W'(1) : timer - GATE_W'(1);
                    GATE: begin
                        acc     <= acc_nxt;
                        ovf_acc <= ovf_nxt;
                        timer   <= timer - GATE_W'(1);
                        if (timer == '0) begin
                            count <= acc_nxt;
                            ovf   <= ovf_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_yen_freq_meter.sv
// Directed bench for yen_freq_meter: a default instance plus a CNT_W=4 instance
// share stimulus; a clock-locked oscillator gives exact, phase-independent edge counts.
module tb_yen_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [3:0]  ch_in;
    logic [1:0]  ch_sel;
    logic [15:0] gate_len;
    logic        start;

    logic        busy, done, ovf;
    logic [15:0] count;
    logic        busy4, done4, ovf4;
    logic [3:0]  count4;

    int checks = 0;
    int errors = 0;

    logic osc     = 1'b0;
    int   osc_cnt = 0;
    int   half    = 5;
    int   ch_mode [4];

    yen_freq_meter #(.CHANNELS(4), .CNT_W(16), .GATE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ch_in(ch_in), .ch_sel(ch_sel),
        .gate_len(gate_len), .start(start), .busy(busy), .done(done),
        .count(count), .ovf(ovf)
    );

    yen_freq_meter #(.CHANNELS(4), .CNT_W(4), .GATE_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ch_in(ch_in), .ch_sel(ch_sel),
        .gate_len(gate_len), .start(start), .busy(busy4), .done(done4),
        .count(count4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    // Oscillator period is 2*half clk cycles, toggled on the falling edge.
    always @(negedge clk) begin
        if (osc_cnt >= half - 1) begin
            osc     <= ~osc;
            osc_cnt <= 0;
        end else begin
            osc_cnt <= osc_cnt + 1;
        end
    end

    always_comb begin
        ch_in = '0;
        for (int i = 0; i < 4; i++)
            ch_in[i] = (ch_mode[i] == 2) ? osc : (ch_mode[i] == 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int ch, input int len);
        ch_sel   = 2'(ch);
        gate_len = 16'(len);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Returns the negedge index (1 = first negedge after the accepting edge)
    // where done first appears, and the first/last index with busy high.
    task automatic measure(input int ch, input int len, input int restart_k,
                           output int done_at, output int bfirst, output int blast);
        done_at = -1;
        bfirst  = 0;
        blast   = 0;
        start_run(ch, len);
        for (int k = 1; k <= len + 10; k++) begin
            if (busy && bfirst == 0) bfirst = k;
            if (busy) blast = k;
            if (done) begin
                done_at = k;
                break;
            end
            if (k == restart_k) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    int d_at, b_first, b_last;

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        start    = 1'b0;
        ch_sel   = '0;
        gate_len = '0;
        for (int i = 0; i < 4; i++) ch_mode[i] = 2;

        // Reset with all channels toggling
        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_flags", {busy, done, ovf}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_count", 32'(count), 0);
        check("post_rst_flags", {busy, done, ovf}, 0);

        // Period 10, gate 100 on channel 1
        half = 5;
        ch_mode[0] = 0; ch_mode[2] = 0; ch_mode[3] = 0;
        repeat (4) @(negedge clk);
        measure(1, 100, 0, d_at, b_first, b_last);
        check("p10_busy_first", b_first, 1);
        check("p10_busy_last", b_last, 102);
        check("p10_done_at", d_at, 103);
        check("p10_count", 32'(count), 10);
        check("p10_ovf", 32'(ovf), 0);

        // Period 4, gate 100: narrow instance saturates, wide one does not
        half = 2;
        repeat (8) @(negedge clk);
        measure(1, 100, 0, d_at, b_first, b_last);
        check("p4_done_at", d_at, 103);
        check("p4_count4", 32'(count4), 15);
        check("p4_ovf4", 32'(ovf4), 1);
        check("p4_count16", 32'(count), 25);
        check("p4_ovf16", 32'(ovf), 0);
        measure(1, 20, 0, d_at, b_first, b_last);
        check("p4g20_count4", 32'(count4), 5);
        check("p4g20_ovf4", 32'(ovf4), 0);

        // Zero-length gate
        measure(1, 0, 0, d_at, b_first, b_last);
        check("g0_done_at", d_at, 1);
        check("g0_busy_never", b_first, 0);
        check("g0_count", 32'(count), 0);
        check("g0_ovf", 32'(ovf), 0);

        // Second start pulse mid-GATE is ignored
        measure(1, 50, 20, d_at, b_first, b_last);
        check("restart_busy_last", b_last, 52);
        check("restart_done_at", d_at, 53);

        // Static channels must not produce edges after a channel switch
        ch_mode[0] = 1; ch_mode[2] = 0;
        repeat (4) @(negedge clk);
        measure(2, 20, 0, d_at, b_first, b_last);
        check("static_ch2_done", d_at, 23);
        check("static_ch2_count", 32'(count), 0);
        measure(0, 20, 0, d_at, b_first, b_last);
        check("static_ch0_done", d_at, 23);
        check("static_ch0_count", 32'(count), 0);

        // Enable drop mid-GATE keeps the previous result
        half = 5;
        repeat (4) @(negedge clk);
        measure(1, 100, 0, d_at, b_first, b_last);
        check("pre_abort_count", 32'(count), 10);
        start_run(1, 100);
        repeat (40) @(negedge clk);
        check("ena_gate_busy", 32'(busy), 1);
        ena = 1'b0;
        @(negedge clk);
        check("ena_abort_flags", {busy, done}, 0);
        check("ena_abort_count", 32'(count), 10);
        repeat (3) @(negedge clk);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        check("ena_restore_idle", {busy, done}, 0);

        // Reset during GATE cycle 30 clears outputs immediately
        start_run(1, 100);
        repeat (31) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_count", 32'(count), 0);
        check("rst_mid_flags", {busy, done, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_idle", {busy, done}, 0);
        check("rst_mid_count_after", 32'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
